// File: rtl/seq_multiplier_pkg.sv
// +----------------------------------------------------------------------+
// | seq_multiplier_pkg : FSM encodings and width helper for seq_multiplier |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package seq_multiplier_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Step counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_multiplier_add_step.sv
// +----------------------------------------------------------------------+
// | mult_add_step : conditional add of shifted multiplicand to accumulator |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_add_step #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [CNT_W-1:0]   shift,
  input  logic               en,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [2*WIDTH-1:0] w_shifted;

  assign w_shifted = {{WIDTH{1'b0}}, mcand} << shift;
  assign acc_out   = en ? (acc_in + w_shifted) : acc_in;

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// +----------------------------------------------------------------------+
// | seq_multiplier : shift-add multiplier, one partial product per clock  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_res
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int RES_W = 2 * WIDTH;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RES_W-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             neg_q,    neg_d;
  logic [RES_W-1:0] res_q,    res_d;

  logic             w_signed_mode;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [RES_W-1:0] w_step_sum;

  generate
    if (SIGNED_EN) begin : g_signed
      assign w_signed_mode = in_signed;
    end else begin : g_unsigned
      assign w_signed_mode = 1'b0;
    end
  endgenerate

  // -2^(WIDTH-1) negates to itself, which read as unsigned is its magnitude.
  assign w_a_mag = (w_signed_mode && in_a[WIDTH-1]) ? -in_a : in_a;
  assign w_b_mag = (w_signed_mode && in_b[WIDTH-1]) ? -in_b : in_b;

  mult_add_step #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_add_step (
    .acc_in  (acc_q),
    .mcand   (mcand_q),
    .shift   (count_q),
    .en      (mplier_q[0]),
    .acc_out (w_step_sum)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_res   = res_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mcand_d  = w_a_mag;
          mplier_d = w_b_mag;
          neg_d    = w_signed_mode & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = w_step_sum;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          res_d   = neg_q ? -w_step_sum : w_step_sum;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// +----------------------------------------------------------------------+
// | tb_seq_multiplier : directed-vector bench for seq_multiplier          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_multiplier;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_res;

  logic        v4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        s4 = 1'b0;
  logic        r4 = 1'b1;
  logic        rdy4s, rdy4u, ov4s, ov4u;
  logic [7:0]  res4s, res4u;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res)
  );

  seq_multiplier #(.WIDTH(4), .SIGNED_EN(1'b1)) u_dut4s (
    .clock(clock), .reset_n(reset_n),
    .in_valid(v4), .in_ready(rdy4s),
    .in_a(a4), .in_b(b4), .in_signed(s4),
    .out_valid(ov4s), .out_ready(r4), .out_res(res4s)
  );

  seq_multiplier #(.WIDTH(4), .SIGNED_EN(1'b0)) u_dut4u (
    .clock(clock), .reset_n(reset_n),
    .in_valid(v4), .in_ready(rdy4u),
    .in_a(a4), .in_b(b4), .in_signed(s4),
    .out_valid(ov4u), .out_ready(r4), .out_res(res4u)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction on the 8-bit instance with out_ready held high.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp, input string tag);
    int lat;
    @(negedge clock);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_res"}, out_res, {16'h0, exp});
    @(posedge clock); #1;
    check({tag, "_rdy"}, {31'h0, in_ready}, 1);
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic [7:0] exp_s, input logic [7:0] exp_u, input string tag);
    int lat;
    @(negedge clock);
    a4 = a; b4 = b; s4 = s; v4 = 1'b1;
    @(posedge clock); #1;
    v4 = 1'b0;
    lat = 0;
    while (!ov4s && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_ovu"}, {31'h0, ov4u}, 1);
    check({tag, "_s"}, {24'h0, res4s}, {24'h0, exp_s});
    check({tag, "_u"}, {24'h0, res4u}, {24'h0, exp_u});
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc;
    logic [15:0] held;
    logic        stable;

    #12;
    check("rst_ready", {31'h0, in_ready}, 1);
    check("rst_valid", {31'h0, out_valid}, 0);
    check("rst_res", {16'h0, out_res}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op8(8'd13,  8'd11,  1'b0, 16'h008F, "u13x11");
    run_op8(8'hFF,  8'hFF,  1'b0, 16'hFE01, "u255x255");
    run_op8(8'h80,  8'h80,  1'b0, 16'h4000, "u80x80");
    run_op8(8'hFD,  8'h05,  1'b1, 16'hFFF1, "sm3x5");
    run_op8(8'h80,  8'h80,  1'b1, 16'h4000, "sm128xm128");
    run_op8(8'h80,  8'h7F,  1'b1, 16'hC080, "sm128x127");
    run_op8(8'h05,  8'hFD,  1'b1, 16'hFFF1, "s5xm3");

    // Consumer stall, then back-to-back with in_valid held high.
    @(negedge clock);
    in_a = 8'd13; in_b = 8'd11; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    in_a = 8'd3;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("stall_lat", cyc, 8);
    check("stall_res", {16'h0, out_res}, 32'h008F);
    held = out_res;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (!out_valid || out_res !== held || in_ready) stable = 1'b0;
    end
    check("stall_stable", {31'h0, stable}, 1);
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("hs_ready", {31'h0, in_ready}, 1);
    check("hs_valid", {31'h0, out_valid}, 0);
    // Edges from the result handshake to the next result: idle + accept + 8 steps less one.
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == 1) in_valid = 1'b0;
    end
    check("b2b_gap", cyc, 9);
    check("b2b_res", {16'h0, out_res}, 32'h0021);
    @(posedge clock); #1;

    // Asynchronous reset in the middle of a calculation.
    @(negedge clock);
    in_a = 8'd100; in_b = 8'd100; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, out_valid}, 0);
    check("arst_res", {16'h0, out_res}, 0);
    check("arst_ready", {31'h0, in_ready}, 1);
    @(negedge clock);
    reset_n = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (out_valid || !in_ready) stable = 1'b0;
    end
    check("arst_quiet", {31'h0, stable}, 1);
    run_op8(8'd6, 8'd7, 1'b0, 16'h002A, "u6x7");

    // Narrow instances: signed-enabled and signed-disabled side by side.
    run_op4(4'd7, 4'd7, 1'b0, 8'h31, 8'h31, "w4_7x7");
    run_op4(4'h8, 4'd7, 1'b1, 8'hC8, 8'h38, "w4_m8x7");
    run_op4(4'hF, 4'hF, 1'b1, 8'h01, 8'hE1, "w4_FxF");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
